// File: rtl/aemb2_wbarb_pkg.sv
`default_nettype none
// aemb2_wbarb_pkg: shared state encodings, arbitration-mode codes and error data
// Revision 1.0
package aemb2_wbarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int ARB_FIX = 0;
  localparam int ARB_RR  = 1;

  // Wide enough for any supported data bus; users slice the low bits.
  localparam logic [255:0] ERR_DATA = '1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aemb2_rrpick.sv
`default_nettype none
// aemb2_rrpick: combinational rotating-priority picker; pointer 0 gives fixed priority
// Revision 1.0
module aemb2_rrpick
  import aemb2_wbarb_pkg::*;
#(
  parameter int NCH = 3,
  parameter int IW  = idx_width(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < NCH; i++) begin
      c = int'(ptr) + i;
      if (c >= NCH) c = c - NCH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aemb2_wbarb.sv
`default_nettype none
// aemb2_wbarb: N-channel Wishbone classic arbiter with fixed/round-robin grant
// and a per-transfer watchdog. Revision 1.0
module aemb2_wbarb
  import aemb2_wbarb_pkg::*;
#(
  parameter int AEMB_NCH = 3,
  parameter int AEMB_AWB = 32,
  parameter int AEMB_DWB = 32,
  parameter int AEMB_ARB = 1,
  parameter int AEMB_TMO = 16
) (
  input  logic                               sys_clk_i,
  input  logic                               sys_rst_i,
  input  logic [AEMB_NCH-1:0]                mwb_cyc_i,
  input  logic [AEMB_NCH-1:0]                mwb_stb_i,
  input  logic [AEMB_NCH-1:0]                mwb_wre_i,
  input  logic [AEMB_NCH*(AEMB_AWB-2)-1:0]   mwb_adr_i,
  input  logic [AEMB_NCH*(AEMB_DWB/8)-1:0]   mwb_sel_i,
  input  logic [AEMB_NCH*AEMB_DWB-1:0]       mwb_dat_i,
  output logic [AEMB_NCH-1:0]                mwb_ack_o,
  output logic [AEMB_DWB-1:0]                mwb_dat_o,
  output logic                               swb_cyc_o,
  output logic                               swb_stb_o,
  output logic                               swb_wre_o,
  output logic [AEMB_AWB-3:0]                swb_adr_o,
  output logic [AEMB_DWB/8-1:0]              swb_sel_o,
  output logic [AEMB_DWB-1:0]                swb_dat_o,
  input  logic                               swb_ack_i,
  input  logic [AEMB_DWB-1:0]                swb_dat_i,
  output logic [AEMB_NCH-1:0]                gnt_o,
  output logic [AEMB_NCH-1:0]                err_o
);

  localparam int AW = AEMB_AWB - 2;
  localparam int SW = AEMB_DWB / 8;
  localparam int IW = idx_width(AEMB_NCH);
  localparam int WW = (AEMB_TMO > 0) ? $clog2(AEMB_TMO + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (AEMB_TMO > 0) ? WW'(AEMB_TMO - 1) : WW'(0);
  localparam logic RR_MODE = (AEMB_ARB == ARB_RR);

  state_t                state, state_nx;
  logic [IW-1:0]         ptr, ptr_eff, win;
  logic [AEMB_NCH-1:0]   req, pick_gnt, cur_oh;
  logic                  any_req, wd_hit, abort;
  logic [WW-1:0]         wd;

  assign req     = mwb_cyc_i & mwb_stb_i;
  assign ptr_eff = RR_MODE ? ptr : IW'(0);

  aemb2_rrpick #(
    .NCH (AEMB_NCH),
    .IW  (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr_eff),
    .gnt (pick_gnt),
    .idx (win),
    .any (any_req)
  );

  // Ack beats abort, abort beats timeout.
  always_comb begin
    state_nx = state;
    wd_hit   = (AEMB_TMO != 0) && (wd == WD_LAST);
    abort    = ~|(mwb_cyc_i & cur_oh);
    case (state)
      ST_IDLE: if (any_req) state_nx = ST_BUSY;
      ST_BUSY: begin
        if (swb_ack_i || abort) state_nx = ST_IDLE;
        else if (wd_hit)        state_nx = ST_ERR;
      end
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mwb_ack_o = '0;
    err_o     = '0;
    mwb_dat_o = swb_dat_i;
    if ((state == ST_BUSY && swb_ack_i) || state == ST_ERR) mwb_ack_o = cur_oh;
    if (state == ST_ERR) begin
      err_o     = cur_oh;
      mwb_dat_o = ERR_DATA[AEMB_DWB-1:0];
    end
    if (sys_rst_i) mwb_dat_o = '0;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      wd        <= '0;
      cur_oh    <= '0;
      gnt_o     <= '0;
      swb_cyc_o <= 1'b0;
      swb_stb_o <= 1'b0;
      swb_wre_o <= 1'b0;
      swb_adr_o <= '0;
      swb_sel_o <= '0;
      swb_dat_o <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && any_req) begin
        cur_oh    <= pick_gnt;
        gnt_o     <= pick_gnt;
        swb_cyc_o <= 1'b1;
        swb_stb_o <= 1'b1;
        swb_wre_o <= mwb_wre_i[win];
        swb_adr_o <= mwb_adr_i[int'(win)*AW +: AW];
        swb_sel_o <= mwb_sel_i[int'(win)*SW +: SW];
        swb_dat_o <= mwb_dat_i[int'(win)*AEMB_DWB +: AEMB_DWB];
        wd        <= '0;
        ptr       <= (int'(win) == AEMB_NCH - 1) ? IW'(0) : win + IW'(1);
      end else if (state == ST_BUSY) begin
        if (wd != {WW{1'b1}}) wd <= wd + WW'(1);
        if (state_nx != ST_BUSY) begin
          gnt_o     <= '0;
          swb_cyc_o <= 1'b0;
          swb_stb_o <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aemb2_wbarb.sv
`default_nettype none
// tb_aemb2_wbarb: directed and randomized checks of the Wishbone arbiter
// Revision 1.0
module tb_aemb2_wbarb;

  localparam int NCH = 3;
  localparam int AWB = 32;
  localparam int DWB = 32;
  localparam int AW  = AWB - 2;
  localparam int SW  = DWB / 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]     m_cyc, m_stb, m_wre;
  logic [NCH*AW-1:0]  m_adr;
  logic [NCH*SW-1:0]  m_sel;
  logic [NCH*DWB-1:0] m_dat;
  logic [NCH-1:0]     ack_o, gnt, err;
  logic [DWB-1:0]     dat_o;
  logic               s_cyc, s_stb, s_wre, s_ack;
  logic [AW-1:0]      s_adr;
  logic [SW-1:0]      s_sel;
  logic [DWB-1:0]     s_dat_o, s_dat_i;

  // Fixed-priority instance with a zero-wait slave
  logic [NCH-1:0]     f_ack_o, f_gnt, f_err;
  logic [DWB-1:0]     f_dat_o, f_s_dat_o, f_s_dat_i;
  logic               f_s_cyc, f_s_stb, f_s_wre, f_s_ack;
  logic [AW-1:0]      f_s_adr;
  logic [SW-1:0]      f_s_sel;

  assign f_s_ack   = f_s_stb;
  assign f_s_dat_i = '0;

  always #5 clk = ~clk;

  aemb2_wbarb #(.AEMB_NCH(NCH), .AEMB_AWB(AWB), .AEMB_DWB(DWB), .AEMB_ARB(1), .AEMB_TMO(TMO)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .mwb_cyc_i(m_cyc), .mwb_stb_i(m_stb), .mwb_wre_i(m_wre),
    .mwb_adr_i(m_adr), .mwb_sel_i(m_sel), .mwb_dat_i(m_dat),
    .mwb_ack_o(ack_o), .mwb_dat_o(dat_o),
    .swb_cyc_o(s_cyc), .swb_stb_o(s_stb), .swb_wre_o(s_wre),
    .swb_adr_o(s_adr), .swb_sel_o(s_sel), .swb_dat_o(s_dat_o),
    .swb_ack_i(s_ack), .swb_dat_i(s_dat_i),
    .gnt_o(gnt), .err_o(err)
  );

  aemb2_wbarb #(.AEMB_NCH(NCH), .AEMB_AWB(AWB), .AEMB_DWB(DWB), .AEMB_ARB(0), .AEMB_TMO(TMO)) u_fix (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .mwb_cyc_i(m_cyc), .mwb_stb_i(m_stb), .mwb_wre_i(m_wre),
    .mwb_adr_i(m_adr), .mwb_sel_i(m_sel), .mwb_dat_i(m_dat),
    .mwb_ack_o(f_ack_o), .mwb_dat_o(f_dat_o),
    .swb_cyc_o(f_s_cyc), .swb_stb_o(f_s_stb), .swb_wre_o(f_s_wre),
    .swb_adr_o(f_s_adr), .swb_sel_o(f_s_sel), .swb_dat_o(f_s_dat_o),
    .swb_ack_i(f_s_ack), .swb_dat_i(f_s_dat_i),
    .gnt_o(f_gnt), .err_o(f_err)
  );

  int total = 0;
  int bad   = 0;
  int rr_p  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input logic [AW-1:0] a, input logic [SW-1:0] s,
                      input logic [DWB-1:0] d, input logic w);
    m_adr[c*AW +: AW]   = a;
    m_sel[c*SW +: SW]   = s;
    m_dat[c*DWB +: DWB] = d;
    m_wre[c]            = w;
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick_rr(input logic [NCH-1:0] r, input int p);
    for (int i = 0; i < NCH; i++)
      if (r[(p + i) % NCH]) return (p + i) % NCH;
    return -1;
  endfunction

  function automatic logic [63:0] oh(input int c);
    return 64'(1) << c;
  endfunction

  initial begin
    int w;
    int ws;
    logic [NCH-1:0] rq;
    logic [DWB-1:0] rd;

    rst = 1'b1; s_ack = 1'b0; s_dat_i = 32'h5A5A_1234;
    m_cyc = '1; m_stb = '1; m_wre = '0; m_adr = '0; m_sel = '0; m_dat = '0;
    for (int c = 0; c < NCH; c++) load(c, AW'($urandom), SW'($urandom), $urandom, 1'b0);

    // Reset holds everything quiet even with requests and slave data present
    tick();
    chk("rst_cyc", 64'(s_cyc), 0);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_ack", 64'(ack_o), 0);
    chk("rst_dat", 64'(dat_o), 0);
    chk("rst_err", 64'(err), 0);
    rst = 1'b0;

    // All channels requesting continuously, zero-wait slave
    rr_p = 0;
    for (int k = 0; k < 6; k++) begin
      w = pick_rr('1, rr_p);
      tick();
      chk("rr_gnt", 64'(gnt), oh(w));
      chk("rr_stb", 64'(s_stb), 1);
      chk("rr_adr", 64'(s_adr), 64'(m_adr[w*AW +: AW]));
      chk("fix_gnt", 64'(f_gnt), 1);
      s_ack = 1'b1; s_dat_i = $urandom; #1;
      chk("rr_ack", 64'(ack_o), oh(w));
      chk("rr_dat", 64'(dat_o), 64'(s_dat_i));
      tick();
      s_ack = 1'b0;
      chk("rr_idle_gnt", 64'(gnt), 0);
      chk("rr_idle_stb", 64'(s_stb), 0);
      chk("fix_idle_gnt", 64'(f_gnt), 0);
      rr_p = (w + 1) % NCH;
    end
    m_cyc = '0; m_stb = '0;
    tick();

    // Single channel read of 0x100 on ch1 with two wait states
    load(1, AW'(32'h100 >> 2), 4'hF, 32'h0, 1'b0);
    m_cyc = 3'b010; m_stb = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("one_stb", 64'(s_stb), 1);
      chk("one_gnt", 64'(gnt), 3'b010);
      chk("one_noack", 64'(ack_o), 0);
    end
    chk("one_adr", 64'(s_adr), 64'h40);
    chk("one_wre", 64'(s_wre), 0);
    s_ack = 1'b1; s_dat_i = 32'hCAFE_F00D; #1;
    chk("one_ack", 64'(ack_o), 3'b010);
    chk("one_dat", 64'(dat_o), 32'hCAFE_F00D);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    chk("one_stb_off", 64'(s_stb), 0);
    rr_p = 2;

    // Randomized transfers against the round-robin rule
    for (int it = 0; it < 20; it++) begin
      rq = NCH'($urandom_range(1, 7));
      for (int c = 0; c < NCH; c++) load(c, AW'($urandom), SW'($urandom), $urandom, 1'($urandom));
      m_cyc = rq; m_stb = rq;
      w  = pick_rr(rq, rr_p);
      ws = $urandom_range(0, 3);
      tick();
      chk("rnd_gnt", 64'(gnt), oh(w));
      chk("rnd_adr", 64'(s_adr), 64'(m_adr[w*AW +: AW]));
      chk("rnd_sel", 64'(s_sel), 64'(m_sel[w*SW +: SW]));
      chk("rnd_wdat", 64'(s_dat_o), 64'(m_dat[w*DWB +: DWB]));
      chk("rnd_wre", 64'(s_wre), 64'(m_wre[w]));
      for (int i = 0; i < ws; i++) begin
        tick();
        chk("rnd_wait_stb", 64'(s_stb), 1);
        chk("rnd_wait_ack", 64'(ack_o), 0);
      end
      rd = $urandom; s_dat_i = rd; s_ack = 1'b1; #1;
      chk("rnd_ack", 64'(ack_o), oh(w));
      chk("rnd_rdat", 64'(dat_o), 64'(rd));
      chk("rnd_err", 64'(err), 0);
      tick();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      chk("rnd_done", 64'(s_cyc), 0);
      rr_p = (w + 1) % NCH;
    end

    // Watchdog: ch2, slave never acks
    m_cyc = 3'b100; m_stb = 3'b100; s_dat_i = $urandom;
    tick();
    chk("wd_gnt", 64'(gnt), 3'b100);
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("wd_stb", 64'(s_stb), 1);
      chk("wd_noack", 64'(ack_o), 0);
    end
    tick();
    chk("wd_ack", 64'(ack_o), 3'b100);
    chk("wd_err", 64'(err), 3'b100);
    chk("wd_dat", 64'(dat_o), 32'hFFFF_FFFF);
    chk("wd_cyc", 64'(s_cyc), 0);
    m_cyc = '0; m_stb = '0;
    tick();
    chk("wd_err_pulse", 64'(err), 0);
    chk("wd_ack_pulse", 64'(ack_o), 0);

    // Ack in the terminal watchdog cycle wins
    m_cyc = 3'b100; m_stb = 3'b100;
    tick();
    for (int i = 1; i < TMO; i++) tick();
    rd = $urandom; s_dat_i = rd; s_ack = 1'b1; #1;
    chk("term_ack", 64'(ack_o), 3'b100);
    chk("term_noerr", 64'(err), 0);
    chk("term_dat", 64'(dat_o), 64'(rd));
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    chk("term_no_err_next", 64'(err), 0);
    chk("term_no_ack_next", 64'(ack_o), 0);
    chk("term_idle", 64'(s_cyc), 0);
    rr_p = 0;

    // Master abort: ch0 drops cyc while ch1 waits
    m_cyc = 3'b011; m_stb = 3'b011;
    w = pick_rr(3'b011, rr_p);
    tick();
    chk("abt_gnt", 64'(gnt), oh(w));
    m_cyc = 3'b010; m_stb = 3'b010;
    tick();
    chk("abt_cyc", 64'(s_cyc), 0);
    chk("abt_noack", 64'(ack_o), 0);
    chk("abt_gnt_off", 64'(gnt), 0);
    tick();
    chk("abt_next_gnt", 64'(gnt), 3'b010);
    s_ack = 1'b1; #1;
    chk("abt_next_ack", 64'(ack_o), 3'b010);
    tick();
    s_ack = 1'b0;
    rr_p = 2;

    // Asynchronous reset in the middle of a ch1 transfer
    tick();
    chk("rstm_gnt", 64'(gnt), 3'b010);
    #2;
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF; rst = 1'b1; #1;
    chk("rstm_cyc", 64'(s_cyc), 0);
    chk("rstm_gnt0", 64'(gnt), 0);
    chk("rstm_ack", 64'(ack_o), 0);
    chk("rstm_dat", 64'(dat_o), 0);
    chk("rstm_adr", 64'(s_adr), 0);
    s_ack = 1'b0; m_cyc = '1; m_stb = '1; rst = 1'b0;
    rr_p = 0;
    w = pick_rr('1, rr_p);
    tick();
    chk("rstm_first_gnt", 64'(gnt), oh(w));
    s_ack = 1'b1; #1;
    chk("rstm_first_ack", 64'(ack_o), oh(w));
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aemb2_wbarb.md
# aemb2_wbarb

Parametrised N-channel Wishbone classic arbiter. It merges the core's master ports (instruction, data and XSL, or more in multi-core builds) onto one shared system bus. It supports fixed-priority or round-robin grant and a per-transfer watchdog that terminates hung slave cycles. It sits between the AEMB2 core's `*wb_*` master ports and the single external memory or peripheral bus.

## Interface
Parameters:
- AEMB_NCH, 3 — number of master channels (1..8)
- AEMB_AWB, 32 — address width; address fields are [AEMB_AWB-1:2]
- AEMB_DWB, 32 — data width; select width is AEMB_DWB/8
- AEMB_ARB, 1 — 0 = fixed priority (channel 0 highest), 1 = round robin
- AEMB_TMO, 16 — watchdog limit in cycles; 0 disables the watchdog

Ports (channel c occupies slice c of each packed vector):
- sys_clk_i  in  1  clock, rising edge
- sys_rst_i  in  1  reset, asynchronous, active-high
- mwb_cyc_i  in  NCH  master cycle
- mwb_stb_i  in  NCH  master strobe
- mwb_wre_i  in  NCH  master write enable
- mwb_adr_i  in  NCH*(AWB-2)  master address
- mwb_sel_i  in  NCH*DWB/8  master byte selects
- mwb_dat_i  in  NCH*DWB  master write data
- mwb_ack_o  out  NCH  per-channel acknowledge
- mwb_dat_o  out  DWB  read data, broadcast to all channels and qualified by mwb_ack_o
- swb_cyc_o, swb_stb_o, swb_wre_o  out  1  slave bus controls, registered
- swb_adr_o  out  AWB-2  slave address, registered
- swb_sel_o  out  DWB/8  slave byte selects, registered
- swb_dat_o  out  DWB  slave write data, registered
- swb_ack_i  in  1  slave acknowledge
- swb_dat_i  in  DWB  slave read data
- gnt_o  out  NCH  one-hot current grant (all zero when idle)
- err_o  out  NCH  one-cycle pulse on a watchdog abort for that channel

## Operation
- A channel requests when mwb_cyc_i[c] and mwb_stb_i[c] are both high.
- The FSM has three states: IDLE, BUSY and ERR.
- IDLE: if any request is present, pick the winner g at the clock edge. Latch g, its adr/sel/dat/wre, and set swb_cyc_o = swb_stb_o = 1 and gnt_o[g] = 1. Go to BUSY.
- Winner selection with AEMB_ARB=0: lowest index wins.
- Winner selection with AEMB_ARB=1: search upward from pointer p, wrapping at NCH. After each grant, p = (g+1) mod NCH.
- BUSY: mwb_ack_o[g] = swb_ack_i (combinational). mwb_dat_o = swb_dat_i at all times.
  - On swb_ack_i, clear swb_cyc/stb and gnt, then go to IDLE.
  - On mwb_cyc_i[g] low (master abort), clear the slave bus, forward no ack, then go to IDLE.
  - On watchdog count == AEMB_TMO-1 with no ack, go to ERR.
- ERR (one cycle): swb_cyc/stb = 0. mwb_ack_o[g] = 1 and mwb_dat_o = all ones. err_o[g] = 1. Then go to IDLE.
- The watchdog counter is ceil(log2(TMO+1)) bits wide. It clears on entry to BUSY and increments each BUSY cycle. It saturates and does not wrap.
- Simultaneous events:
  - swb_ack_i in the terminal watchdog cycle: ack wins, and no err is raised.
  - Abort together with ack: the ack is forwarded and the next state is IDLE.
- Requests from non-granted channels are held pending. No ack is ever given to a channel that is not granted.
- Reset, including mid-transfer: state = IDLE, p = 0, counter = 0. All outputs are 0, including mwb_ack_o and mwb_dat_o (mwb_dat_o is forced to 0 while sys_rst_i is high). The in-flight transfer is dropped silently.

## Timing
- Grant latency: a request visible before edge k is granted at edge k, with swb_stb_o high in cycle k.
- Ack passes from slave to master with zero latency. On the edge where the master samples ack, the FSM returns to IDLE. The earliest next grant is one cycle later.
- Minimum transfer period: 2 cycles plus the slave wait states.
- Watchdog abort: mwb_ack_o rises exactly AEMB_TMO cycles after swb_stb_o rose, and lasts 1 cycle.
- The slave bus is stable for the whole of BUSY. Its outputs change only at grant, ack, abort or timeout.

## Structure
- Shared package aemb2_wbarb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_ERR=2'd2;
  - arbitration-mode constants ARB_FIX=0, ARB_RR=1;
  - the all-ones error-data constant.
- Sub-module aemb2_rrpick: combinational picker taking a request vector and a pointer, producing a one-hot grant and its encoded index. It serves both modes; fixed priority uses pointer 0.
- The top level contains the FSM, pointer, watchdog, latched request registers and the return-ack demux.

## Test plan
- Single channel: ch1 reads address 0x100 and the slave acks after 2 wait states with 0xCAFEF00D. Expect swb_stb_o high for 3 cycles, mwb_ack_o = 3'b010 for one cycle, and mwb_dat_o = 0xCAFEF00D.
- Round robin: all 3 channels request continuously with zero-wait acks. Expect grant order 0,1,2,0,1,2 and one transfer every 2 cycles. With AEMB_ARB=0, expect grants to ch0 only.
- Watchdog: AEMB_TMO=16 and the slave never acks on ch2. Expect mwb_ack_o[2] and err_o[2] in cycle 16, mwb_dat_o = 0xFFFFFFFF, and swb_cyc_o low.
- Ack in the terminal watchdog cycle: expect a normal ack, err_o = 0, and the slave data forwarded.
- Master abort: ch0 drops cyc in BUSY. Expect swb_cyc_o low next cycle, no mwb_ack_o, and a pending ch1 request granted one cycle later.
- Reset asserted asynchronously mid-BUSY. Expect all outputs 0 immediately and the first post-reset grant to go to ch0 in RR mode.
